// File: rtl/rng_address_gen_pkg.sv
// Shared definitions for the rng_address_gen block: the codebase word width,
// the iteration counter width and the FSM state encodings. The encodings are
// fixed values so the policy-block bench can decode the exported state.
package rng_address_gen_pkg;

    localparam int WORD_WIDTH     = 16;
    localparam int ITER_CNT_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } rng_state_e;

    // True when the remainder can be produced without iterating:
    // a zero divisor (index 0) or a dividend already below the divisor.
    function automatic logic is_trivial(input logic [WORD_WIDTH-1:0] dvd,
                                        input logic [WORD_WIDTH-1:0] dvs);
        return (dvs == '0) || (dvd < dvs);
    endfunction

    // Result for the trivial cases; only meaningful when is_trivial() holds.
    function automatic logic [WORD_WIDTH-1:0] trivial_result(input logic [WORD_WIDTH-1:0] dvd,
                                                             input logic [WORD_WIDTH-1:0] dvs);
        return (dvs == '0) ? '0 : dvd;
    endfunction

endpackage

// File: rtl/rng_address_gen_serial_remainder.sv
// Serial restoring remainder datapath. load captures the operands and clears
// the partial remainder; each step consumes one dividend bit, MSB first.
// rem_step is the partial remainder the current step will produce, so the
// owner can capture the final value on the step where last is high.
module rng_address_gen_serial_remainder #(
    parameter int WIDTH      = 16,
    parameter int ITER_CNT_W = 5
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dvd_in,
    input  logic [WIDTH-1:0] dvs_in,
    output logic [WIDTH-1:0] rem_step,
    output logic             last
);

    logic [WIDTH-1:0]      dvd_q;
    logic [WIDTH-1:0]      dvs_q;
    logic [WIDTH-1:0]      rem_q;
    logic [ITER_CNT_W-1:0] cnt_q;

    // One extra bit keeps the compare exact when the divisor has its MSB set.
    logic [WIDTH:0] rem_shift;
    logic           rem_ge;

    // Shift-in of the next dividend bit and conditional subtract of the divisor.
    always_comb begin
        rem_shift = {rem_q, dvd_q[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, dvs_q});
        // When rem_ge holds the difference is below the divisor, so the
        // dropped top bit of the subtraction is always zero.
        rem_step  = rem_ge ? (rem_shift[WIDTH-1:0] - dvs_q) : rem_shift[WIDTH-1:0];
        last      = (cnt_q == ITER_CNT_W'(1));
    end

    // Operand capture on load, one quotient-bit iteration per step.
    always_ff @(posedge clock) begin
        if (rst) begin
            dvd_q <= '0;
            dvs_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            dvd_q <= dvd_in;
            dvs_q <= dvs_in;
            rem_q <= '0;
            cnt_q <= ITER_CNT_W'(WIDTH);
        end else if (step) begin
            dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
            rem_q <= rem_step;
            cnt_q <= cnt_q - ITER_CNT_W'(1);
        end
    end

endmodule

// File: rtl/rng_address_gen.sv
// Responder for the start_rngAddress / done_rng_address handshake from the
// next-hop selection policy block. Returns which mod betterNeighborCount,
// using fast paths for a zero divisor or a dividend below the divisor and a
// serial remainder unit otherwise.
//
// Handshake: start_rngAddress is a request level held by the requester until
// it has seen done_rng_address, and it is still high in the cycle after done.
// A job is accepted in IDLE only when start is high and the block is armed;
// acceptance disarms, and any cycle with start low re-arms, so a level held
// high produces exactly one job. done_rng_address is a one-cycle pulse and
// rng_address holds the result from that cycle until the next result or reset.
// busy is high from the acceptance cycle through the done cycle.
module rng_address_gen
    import rng_address_gen_pkg::*;
#(
    parameter int WIDTH      = WORD_WIDTH,
    parameter int ITER_CNT_W = ITER_CNT_WIDTH
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start_rngAddress,
    input  logic [WIDTH-1:0] which,
    input  logic [WIDTH-1:0] betterNeighborCount,
    output logic [WIDTH-1:0] rng_address,
    output logic             done_rng_address,
    output logic             busy,
    output rng_state_e       state_dbg
);

    rng_state_e       state_q;
    rng_state_e       state_d;
    logic             armed_q;
    logic             accept;
    logic             calc_load;
    logic             calc_step;
    logic             addr_load;
    logic [WIDTH-1:0] addr_d;
    logic [WIDTH-1:0] rem_step;
    logic             rem_last;

    rng_address_gen_serial_remainder #(
        .WIDTH      (WIDTH),
        .ITER_CNT_W (ITER_CNT_W)
    ) u_serial_remainder (
        .clock  (clock),
        .rst    (rst),
        .load   (calc_load),
        .step   (calc_step),
        .dvd_in (which),
        .dvs_in (betterNeighborCount),
        .rem_step (rem_step),
        .last   (rem_last)
    );

    // Acceptance, next-state selection and result capture strobes.
    always_comb begin
        state_d   = state_q;
        calc_load = 1'b0;
        calc_step = 1'b0;
        addr_load = 1'b0;
        addr_d    = rng_address;
        accept    = (state_q == IDLE) && start_rngAddress && armed_q && !rst;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_trivial(which, betterNeighborCount)) begin
                        state_d   = DONE;
                        addr_load = 1'b1;
                        addr_d    = trivial_result(which, betterNeighborCount);
                    end else begin
                        state_d   = CALC;
                        calc_load = 1'b1;
                    end
                end
            end
            CALC: begin
                calc_step = 1'b1;
                if (rem_last) begin
                    state_d   = DONE;
                    addr_load = 1'b1;
                    addr_d    = rem_step;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; a reset mid-job abandons it without a done pulse.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Arming: cleared by acceptance, set by any cycle with start low.
    always_ff @(posedge clock) begin
        if (rst) begin
            armed_q <= 1'b1;
        end else if (accept) begin
            armed_q <= 1'b0;
        end else if (!start_rngAddress) begin
            armed_q <= 1'b1;
        end
    end

    // Result register, written only on entry to DONE.
    always_ff @(posedge clock) begin
        if (rst) begin
            rng_address <= '0;
        end else if (addr_load) begin
            rng_address <= addr_d;
        end
    end

    // Status outputs derived from the state and the acceptance decision.
    always_comb begin
        done_rng_address = (state_q == DONE);
        busy             = (state_q != IDLE) || accept;
        state_dbg        = state_q;
    end

endmodule

// File: tb/tb_rng_address_gen.sv
// Bench for rng_address_gen: directed jobs with hand-computed results and
// latencies, plus a cycle-level model compared against the outputs on every
// falling edge.
module tb_rng_address_gen;
    import rng_address_gen_pkg::*;

    localparam int W = 16;

    logic         clock = 1'b0;
    logic         rst;
    logic         start_rngAddress;
    logic [W-1:0] which;
    logic [W-1:0] betterNeighborCount;
    logic [W-1:0] rng_address;
    logic         done_rng_address;
    logic         busy;
    rng_state_e   state_dbg;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit checking  = 1'b0;

    // Model state: cycles remaining before the done cycle, done flag, arming,
    // pending result and the value rng_address must hold.
    int           m_left  = 0;
    bit           m_done  = 1'b0;
    bit           m_armed = 1'b1;
    logic [W-1:0] m_res   = '0;
    logic [W-1:0] m_addr  = '0;

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    rng_address_gen dut (
        .clock               (clock),
        .rst                 (rst),
        .start_rngAddress    (start_rngAddress),
        .which               (which),
        .betterNeighborCount (betterNeighborCount),
        .rng_address         (rng_address),
        .done_rng_address    (done_rng_address),
        .busy                (busy),
        .state_dbg           (state_dbg)
    );

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] ref_index(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
        if (dvs == 0) return '0;
        return dvd % dvs;
    endfunction

    function automatic int ref_latency(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
        if (dvs == 0 || dvd < dvs) return 1;
        return W + 1;
    endfunction

    always @(posedge clock) begin
        bit idle;
        bit acc;
        int lat_m;
        idle = (m_left == 0) && !m_done;
        if (rst) begin
            m_left  = 0;
            m_done  = 1'b0;
            m_armed = 1'b1;
            m_addr  = '0;
        end else begin
            acc    = idle && start_rngAddress && m_armed;
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_addr = m_res;
                end
            end
            if (acc) begin
                m_res = ref_index(which, betterNeighborCount);
                lat_m = ref_latency(which, betterNeighborCount);
                if (lat_m == 1) begin
                    m_done = 1'b1;
                    m_addr = m_res;
                end else begin
                    m_left = lat_m - 1;
                end
            end
            if (acc) m_armed = 1'b0;
            else if (!start_rngAddress) m_armed = 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clock) begin
        bit         exp_busy;
        rng_state_e exp_state;
        if (checking) begin
            exp_busy  = (m_left > 0) || m_done ||
                        ((m_left == 0) && !m_done && start_rngAddress && m_armed && !rst);
            exp_state = m_done ? DONE : ((m_left > 0) ? CALC : IDLE);
            check("cyc_done",  {31'd0, done_rng_address}, {31'd0, m_done});
            check("cyc_busy",  {31'd0, busy}, {31'd0, exp_busy});
            check("cyc_addr",  {16'd0, rng_address}, {16'd0, m_addr});
            check("cyc_state", {30'd0, state_dbg}, {30'd0, exp_state});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Raises start with the operands, waits for done, checks the literal
    // result, latency and busy span, then keeps start high for 1+hold cycles
    // after done before dropping it for one cycle.
    task automatic run_job(input string name, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                           input logic [W-1:0] exp_addr, input int exp_lat,
                           input int hold, input bit scramble);
        int lat;
        int busy_n;
        int extra_done;
        bit seen;
        logic [W-1:0] addr_at_done;
        which               = dvd;
        betterNeighborCount = dvs;
        start_rngAddress    = 1'b1;
        lat = -1; busy_n = 0; extra_done = 0; seen = 1'b0; addr_at_done = '0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            if (busy) busy_n++;
            if (done_rng_address) begin
                seen         = 1'b1;
                lat          = i;
                addr_at_done = rng_address;
            end else if (scramble && i > 0) begin
                which               = W'($urandom_range(0, 65535));
                betterNeighborCount = W'($urandom_range(0, 65535));
            end
        end
        check({name, "_seen"}, {31'd0, seen}, 32'd1);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_addr"}, {16'd0, addr_at_done}, {16'd0, exp_addr});
        check({name, "_busy_cycles"}, busy_n, exp_lat + 1);
        for (int k = 0; k <= hold; k++) begin
            @(negedge clock);
            if (done_rng_address) extra_done++;
        end
        check({name, "_single_done"}, extra_done, 0);
        @(posedge clock);
        #1;
        start_rngAddress = 1'b0;
        tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int stray_done;
        rst                 = 1'b1;
        start_rngAddress    = 1'b0;
        which               = '0;
        betterNeighborCount = '0;
        tick();
        checking = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clock);
        check("reset_addr",  {16'd0, rng_address}, 32'd0);
        check("reset_done",  {31'd0, done_rng_address}, 32'd0);
        check("reset_busy",  {31'd0, busy}, 32'd0);
        check("reset_state", {30'd0, state_dbg}, {30'd0, IDLE});
        tick();

        // Fast path, general path, MSB-set divisor, divide by zero.
        run_job("fast",    16'd3,      16'd5,      16'd3,      1,  0, 1'b0);
        run_job("general", 16'h0017,   16'd5,      16'd3,      17, 0, 1'b0);
        run_job("bigdvs",  16'hFFFF,   16'h8001,   16'h7FFE,   17, 0, 1'b0);
        run_job("div0",    16'd9,      16'd0,      16'd0,      1,  0, 1'b0);

        // Start held high 5 cycles past done, then one low cycle re-arms.
        run_job("hold",    16'd40,     16'd6,      16'd4,      17, 4, 1'b0);
        run_job("rearm",   16'd10,     16'd4,      16'd2,      17, 0, 1'b0);

        // Reset during the 8th CALC cycle abandons the job.
        which               = 16'h1234;
        betterNeighborCount = 16'd7;
        start_rngAddress    = 1'b1;
        tick();
        start_rngAddress = 1'b0;
        repeat (7) tick();
        check("midrst_in_calc", {30'd0, state_dbg}, {30'd0, CALC});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clock);
        check("midrst_addr", {16'd0, rng_address}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        stray_done = done_rng_address ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (done_rng_address) stray_done++;
        end
        check("midrst_no_done", stray_done, 0);
        tick();
        run_job("after_rst", 16'd7,    16'd3,      16'd1,      17, 0, 1'b0);

        // Operands scrambled every cycle while the job runs.
        run_job("stable",  16'hBEEF,   16'h00FF,   16'h00AE,   17, 0, 1'b1);

        repeat (3) tick();
        checking = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rng_address_gen.md
Name: rng_address_gen

Overview:
- Responder side of the start_rngAddress / done_rng_address handshake issued by the next-hop selection policy block.
- Takes the random draw `which` and the latched betterNeighborCount, and returns `rng_address = which mod betterNeighborCount`.
- The policy block uses this index to form the betterNeighbor table address (0x668 + 2*index).
- A serial restoring remainder unit does the work: one quotient bit per clock, with fast paths for trivial operands.

Parameters:
- WIDTH, 16, operand/result width; equals the codebase word width.
- ITER_CNT_W, 5, width of the iteration counter; must satisfy 2^ITER_CNT_W > WIDTH.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_rngAddress  in  1  request level from the policy block; held high until it observes done.
- which  in  WIDTH  dividend (random draw); sampled only on job acceptance.
- betterNeighborCount  in  WIDTH  divisor; sampled only on job acceptance.
- rng_address  out  WIDTH  remainder result; stable from the done cycle until the next job is accepted.
- done_rng_address  out  1  one-cycle pulse marking rng_address valid.
- busy  out  1  high from acceptance through the done cycle.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, rng_address=0, done_rng_address=0, busy=0, iteration counter=0, armed=1.
  - A reset during CALC abandons the job; no done pulse is produced for it.
- Arming rule: the requester drops start one cycle after seeing done, so start is still high in the cycle after done.
  - A new job is accepted only when start=1 and armed=1.
  - armed clears on acceptance and sets again in any cycle where start=0.
- States:
  - IDLE: on accept at edge T, latch which→dvd and betterNeighborCount→dvs, set busy=1.
    - If dvs==0: next state DONE with result 0 (divide-by-zero policy: index 0).
    - Else if which<betterNeighborCount: next state DONE with result=which (fast path).
    - Else: next state CALC with rem=0, counter=WIDTH.
  - CALC: each cycle, rem17 = {rem[WIDTH-1:0], dvd[WIDTH-1]}; dvd shifts left by 1.
    - If rem17 >= {1'b0,dvs}, rem = rem17 - dvs; else rem = rem17[WIDTH-1:0].
    - Counter decrements; when it reaches 1, rem is final and the next state is DONE.
    - Exactly WIDTH CALC cycles.
  - DONE: rng_address driven with the result, done_rng_address=1 for exactly this cycle, then IDLE, busy=0.
- Latency from the accept edge to done high:
  - 1 cycle on the fast path or divide-by-zero path.
  - WIDTH+1 cycles on the general path.
- Arithmetic: all unsigned. The result is always < betterNeighborCount when the count is nonzero. 17-bit compare/subtract prevents overflow for dvs ≥ 0x8000.
- Operand changes while busy are ignored. start going low while busy does not abort the job; done is still produced.
- start held high continuously produces exactly one job, because armed stays 0.
- rng_address is unchanged in cycles other than DONE and reset.

Decomposition:
- Shared defines file: WORD_WIDTH (16) and the state encodings IDLE/CALC/DONE, so the policy-block bench can decode them.
- One natural sub-module, serial_remainder: load/step/finish interface holding the dvd/rem/counter datapath. rng_address_gen keeps the FSM, arming logic and fast paths.

Test Plan:
- Fast path: which=3, count=5, pulse start → done 1 cycle after accept, rng_address=3, busy high 2 cycles total.
- General path: which=0x0017 (23), count=5 → done WIDTH+1=17 cycles after accept, rng_address=3; also which=0xFFFF, count=0x8001 → rng_address=0x7FFE.
- Divide-by-zero: count=0, which=9 → done after 1 cycle, rng_address=0.
- Handshake re-arm: start held high 5 cycles past done → exactly one done pulse. Drop start 1 cycle, raise it with which=10, count=4 → second done, rng_address=2.
- Reset mid-op: assert rst on the 8th CALC cycle → no done pulse, rng_address=0, busy=0. A following job (which=7, count=3) returns 1.
- Operand stability: change which/count every cycle during CALC → result still reflects the values latched at acceptance.
